// File: rtl/skolem_sweep_ctrl.sv
// Exhaustive sweep controller for a combinational Skolem netlist: drives every
// input vector, checks the FUT output against the parity relation, and reports a verdict.
module skolem_sweep_ctrl #(
  parameter int N_IN     = 7,
  parameter int SETTLE   = 1,
  parameter bit INV_SPEC = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  output logic [N_IN-1:0] vec_out,
  input  logic            fut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            aborted,
  output logic [N_IN:0]   mismatch_cnt,
  output logic            cex_valid,
  output logic [N_IN-1:0] first_cex
);

  typedef enum logic [1:0] {IDLE, HOLD, SAMPLE, FIN} state_t;

  localparam logic [3:0]      SETTLE_CNT = 4'(SETTLE);
  localparam logic [N_IN-1:0] VEC_ONE    = N_IN'(1);
  localparam logic [N_IN:0]   CNT_ONE    = (N_IN + 1)'(1);

  state_t     state;
  logic [3:0] hold_cnt;
  logic       expected;
  logic       miss;

  // Reference relation: even parity of the vector, optionally inverted.
  assign expected = (^vec_out) ^ INV_SPEC;
  assign miss     = (fut_out != expected);

  // NOTE: every register here is updated with non-blocking assignments so all
  // next-state decisions read the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      hold_cnt     <= 4'd0;
      vec_out      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      aborted      <= 1'b0;
      mismatch_cnt <= '0;
      cex_valid    <= 1'b0;
      first_cex    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mismatch_cnt <= '0;
            cex_valid    <= 1'b0;
            first_cex    <= '0;
            pass         <= 1'b0;
            aborted      <= 1'b0;
            vec_out      <= '0;
            hold_cnt     <= SETTLE_CNT;
            busy         <= 1'b1;
            state        <= (SETTLE == 0) ? SAMPLE : HOLD;
          end
        end

        HOLD: begin
          if (abort) begin
            aborted <= 1'b1;
            done    <= 1'b1;
            state   <= FIN;
          end else begin
            hold_cnt <= hold_cnt - 4'd1;
            if (hold_cnt <= 4'd1) state <= SAMPLE;
          end
        end

        SAMPLE: begin
          // An abort discards this cycle's comparison entirely.
          if (abort) begin
            aborted <= 1'b1;
            done    <= 1'b1;
            state   <= FIN;
          end else begin
            if (miss) begin
              mismatch_cnt <= mismatch_cnt + CNT_ONE;
              if (!cex_valid) begin
                cex_valid <= 1'b1;
                first_cex <= vec_out;
              end
            end
            if (&vec_out) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              vec_out  <= vec_out + VEC_ONE;
              hold_cnt <= SETTLE_CNT;
              state    <= (SETTLE == 0) ? SAMPLE : HOLD;
            end
          end
        end

        FIN: begin
          pass  <= (mismatch_cnt == '0) && !aborted;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_skolem_sweep_ctrl.sv
// Bench for skolem_sweep_ctrl: three instances (SETTLE 1, 0, and 2 with inverted
// spec) driven against truth tables; results compared with a vector-level model.
module tb_skolem_sweep_ctrl;
  localparam int NV = 128;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_s [3];
  logic       abort_s [3];
  logic       fut_s   [3];
  logic [6:0] vec     [3];
  logic [6:0] cex_o   [3];
  logic       busy_o  [3];
  logic       done_o  [3];
  logic       pass_o  [3];
  logic       abrt_o  [3];
  logic       cexv_o  [3];
  logic [7:0] cnt_o   [3];
  logic [NV-1:0] tbl  [3];

  int total = 0;
  int bad   = 0;
  int r_busy, r_done, r_done_at, r_seq_err;
  bit r_timeout;

  always #5 clk = ~clk;

  assign fut_s[0] = tbl[0][vec[0]];
  assign fut_s[1] = tbl[1][vec[1]];
  assign fut_s[2] = tbl[2][vec[2]];

  skolem_sweep_ctrl #(.N_IN(7), .SETTLE(1), .INV_SPEC(1'b0)) dut_s1 (
    .clk(clk), .rst(rst), .start(start_s[0]), .abort(abort_s[0]), .vec_out(vec[0]),
    .fut_out(fut_s[0]), .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]),
    .aborted(abrt_o[0]), .mismatch_cnt(cnt_o[0]), .cex_valid(cexv_o[0]), .first_cex(cex_o[0]));

  skolem_sweep_ctrl #(.N_IN(7), .SETTLE(0), .INV_SPEC(1'b0)) dut_s0 (
    .clk(clk), .rst(rst), .start(start_s[1]), .abort(abort_s[1]), .vec_out(vec[1]),
    .fut_out(fut_s[1]), .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]),
    .aborted(abrt_o[1]), .mismatch_cnt(cnt_o[1]), .cex_valid(cexv_o[1]), .first_cex(cex_o[1]));

  skolem_sweep_ctrl #(.N_IN(7), .SETTLE(2), .INV_SPEC(1'b1)) dut_inv (
    .clk(clk), .rst(rst), .start(start_s[2]), .abort(abort_s[2]), .vec_out(vec[2]),
    .fut_out(fut_s[2]), .busy(busy_o[2]), .done(done_o[2]), .pass(pass_o[2]),
    .aborted(abrt_o[2]), .mismatch_cnt(cnt_o[2]), .cex_valid(cexv_o[2]), .first_cex(cex_o[2]));

  function automatic int settle_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 0 : 2;
  endfunction

  // Relation the FUT should implement: parity of v, inverted for instance 2.
  function automatic logic spec_bit(input int k, input int v);
    logic [6:0] vv;
    vv = v[6:0];
    return (^vv) ^ (k == 2);
  endfunction

  // mode 0 correct, 1 stuck-at-0, 2 inverted, 3 wrong only at errv, 4 random errors
  task automatic set_table(input int k, input int mode, input int errv);
    for (int v = 0; v < NV; v++) begin
      case (mode)
        0:       tbl[k][v] = spec_bit(k, v);
        1:       tbl[k][v] = 1'b0;
        2:       tbl[k][v] = ~spec_bit(k, v);
        3:       tbl[k][v] = spec_bit(k, v) ^ (v == errv);
        default: tbl[k][v] = spec_bit(k, v) ^ ($urandom_range(0, 3) == 0);
      endcase
    end
  endtask

  // Expected mismatches over vectors [0, limit) and the lowest failing vector.
  function automatic void model(input int k, input int limit, output int cnt, output int first);
    cnt   = 0;
    first = -1;
    for (int v = 0; v < limit; v++) begin
      if (tbl[k][v] != spec_bit(k, v)) begin
        if (first < 0) first = v;
        cnt++;
      end
    end
  endfunction

  // Starts a sweep from the current negedge and follows it until busy drops.
  task automatic run_sweep(input int k, input int abort_vec, input bit stray);
    int s, last, ev;
    s    = settle_of(k);
    last = (abort_vec >= 0) ? abort_vec : NV - 1;
    r_busy = 0; r_done = 0; r_done_at = -1; r_seq_err = 0; r_timeout = 1'b1;
    start_s[k] = 1'b1;
    @(negedge clk);
    start_s[k] = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (!busy_o[k]) begin
        r_timeout = 1'b0;
        break;
      end
      ev = c / (s + 1);
      if (ev > last) ev = last;
      if (int'(vec[k]) != ev) r_seq_err++;
      if (done_o[k]) begin
        r_done++;
        r_done_at = c;
      end
      abort_s[k] = (abort_vec >= 0) && (c / (s + 1) == abort_vec) && (c % (s + 1) == s);
      start_s[k] = stray && (c == 3 || c == 2 * (s + 1) + s);
      r_busy++;
      @(negedge clk);
    end
    abort_s[k] = 1'b0;
    start_s[k] = 1'b0;
  endtask

  task automatic test_reset;
    logic [24:0] got;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      got = {vec[k], busy_o[k], done_o[k], pass_o[k], abrt_o[k], cnt_o[k], cexv_o[k], cex_o[k]};
      total++;
      if (got !== '0) begin
        bad++;
        $display("FAIL reset_state[%0d]: got %h want 0", k, got);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({busy_o[0], busy_o[1], busy_o[2]} !== 3'b000) begin
      bad++;
      $display("FAIL idle_after_reset: busy=%b%b%b want 000", busy_o[0], busy_o[1], busy_o[2]);
    end
  endtask

  task automatic test_correct;
    logic [24:0] got;
    set_table(0, 0, 0);
    run_sweep(0, -1, 1'b0);
    total++;
    if (r_timeout || r_busy != 257 || r_done != 1 || r_done_at != 256 || r_seq_err != 0) begin
      bad++;
      $display("FAIL correct_timing: busy=%0d done=%0d at=%0d seq_err=%0d timeout=%0b want 257/1/256/0/0",
               r_busy, r_done, r_done_at, r_seq_err, r_timeout);
    end
    got = {pass_o[0], abrt_o[0], cnt_o[0], cexv_o[0], cex_o[0], vec[0]};
    total++;
    if (got !== {1'b1, 1'b0, 8'd0, 1'b0, 7'h00, 7'h7F}) begin
      bad++;
      $display("FAIL correct_result: got %h want %h", got, {1'b1, 1'b0, 8'd0, 1'b0, 7'h00, 7'h7F});
    end
  endtask

  task automatic test_stuck0;
    logic [24:0] got;
    set_table(0, 1, 0);
    run_sweep(0, -1, 1'b0);
    got = {pass_o[0], abrt_o[0], cnt_o[0], cexv_o[0], cex_o[0], vec[0]};
    total++;
    if (r_timeout || r_busy != 257 || got !== {1'b0, 1'b0, 8'd64, 1'b1, 7'h01, 7'h7F}) begin
      bad++;
      $display("FAIL stuck0: busy=%0d got %h want busy=257 %h", r_busy, got,
               {1'b0, 1'b0, 8'd64, 1'b1, 7'h01, 7'h7F});
    end
  endtask

  task automatic test_inverted;
    logic [24:0] got;
    set_table(1, 2, 0);
    run_sweep(1, -1, 1'b0);
    total++;
    if (r_timeout || r_busy != 129 || r_done != 1 || r_done_at != 128 || r_seq_err != 0) begin
      bad++;
      $display("FAIL inverted_timing: busy=%0d done=%0d at=%0d seq_err=%0d want 129/1/128/0",
               r_busy, r_done, r_done_at, r_seq_err);
    end
    got = {pass_o[1], abrt_o[1], cnt_o[1], cexv_o[1], cex_o[1], vec[1]};
    total++;
    if (got !== {1'b0, 1'b0, 8'd128, 1'b1, 7'h00, 7'h7F}) begin
      bad++;
      $display("FAIL inverted_result: got %h want %h", got, {1'b0, 1'b0, 8'd128, 1'b1, 7'h00, 7'h7F});
    end
  endtask

  task automatic test_abort;
    logic [24:0] got;
    set_table(0, 1, 0);
    run_sweep(0, 16, 1'b0);
    total++;
    if (r_timeout || r_busy != 35 || r_done != 1 || r_done_at != 34 || r_seq_err != 0) begin
      bad++;
      $display("FAIL abort_timing: busy=%0d done=%0d at=%0d seq_err=%0d want 35/1/34/0",
               r_busy, r_done, r_done_at, r_seq_err);
    end
    got = {pass_o[0], abrt_o[0], cnt_o[0], cexv_o[0], cex_o[0], vec[0]};
    total++;
    if (got !== {1'b0, 1'b1, 8'd8, 1'b1, 7'h01, 7'h10}) begin
      bad++;
      $display("FAIL abort_result: got %h want %h", got, {1'b0, 1'b1, 8'd8, 1'b1, 7'h01, 7'h10});
    end
  endtask

  task automatic test_reset_mid;
    logic [24:0] got, want;
    bit found;
    int cnt, first;
    set_table(0, 0, 0);
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (vec[0] == 7'h40) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL reset_mid_reach: vec=%h never reached 40", vec[0]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    got = {vec[0], busy_o[0], done_o[0], pass_o[0], abrt_o[0], cnt_o[0], cexv_o[0], cex_o[0]};
    total++;
    if (got !== '0) begin
      bad++;
      $display("FAIL reset_mid_clear: got %h want 0", got);
    end
    @(negedge clk);
    total++;
    if (done_o[0] !== 1'b0 || busy_o[0] !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_nodone: done=%b busy=%b want 0 0", done_o[0], busy_o[0]);
    end
    // Restart with stray start pulses while busy; the sweep must be unaffected.
    set_table(0, 4, 0);
    run_sweep(0, -1, 1'b1);
    model(0, NV, cnt, first);
    got  = {pass_o[0], abrt_o[0], cnt_o[0], cexv_o[0], cex_o[0], vec[0]};
    want = {cnt == 0, 1'b0, 8'(cnt), cnt > 0, 7'(first < 0 ? 0 : first), 7'h7F};
    total++;
    if (r_timeout || r_busy != 257 || r_seq_err != 0 || r_done != 1 || got !== want) begin
      bad++;
      $display("FAIL restart_stray_start: busy=%0d seq_err=%0d done=%0d got %h want busy=257 %h",
               r_busy, r_seq_err, r_done, got, want);
    end
  endtask

  task automatic test_single_bit;
    logic [24:0] got, want;
    int ev;
    set_table(0, 3, 'h5A);
    run_sweep(0, -1, 1'b0);
    got = {pass_o[0], abrt_o[0], cnt_o[0], cexv_o[0], cex_o[0], vec[0]};
    total++;
    if (got !== {1'b0, 1'b0, 8'd1, 1'b1, 7'h5A, 7'h7F}) begin
      bad++;
      $display("FAIL single_bit_5a: got %h want %h", got, {1'b0, 1'b0, 8'd1, 1'b1, 7'h5A, 7'h7F});
    end
    ev = $urandom_range(0, NV - 1);
    set_table(2, 3, ev);
    run_sweep(2, -1, 1'b0);
    got  = {pass_o[2], abrt_o[2], cnt_o[2], cexv_o[2], cex_o[2], vec[2]};
    want = {1'b0, 1'b0, 8'd1, 1'b1, 7'(ev), 7'h7F};
    total++;
    if (r_timeout || r_busy != 385 || r_seq_err != 0 || got !== want) begin
      bad++;
      $display("FAIL single_bit_inv: busy=%0d seq_err=%0d got %h want busy=385 %h",
               r_busy, r_seq_err, got, want);
    end
  endtask

  task automatic test_random;
    logic [24:0] got, want;
    int k, s, ab, cnt, first, exp_busy;
    for (int it = 0; it < 8; it++) begin
      k  = $urandom_range(0, 2);
      s  = settle_of(k);
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, NV - 1) : -1;
      set_table(k, 4, 0);
      run_sweep(k, ab, 1'b0);
      model(k, (ab < 0) ? NV : ab, cnt, first);
      exp_busy = ((ab < 0) ? NV : ab + 1) * (s + 1) + 1;
      got  = {pass_o[k], abrt_o[k], cnt_o[k], cexv_o[k], cex_o[k], vec[k]};
      want = {(cnt == 0) && (ab < 0), ab >= 0, 8'(cnt), cnt > 0,
              7'(first < 0 ? 0 : first), 7'((ab < 0) ? NV - 1 : ab)};
      total++;
      if (r_timeout || r_busy != exp_busy || r_done != 1 || r_done_at != exp_busy - 1 ||
          r_seq_err != 0 || got !== want) begin
        bad++;
        $display("FAIL random[%0d] k=%0d abort=%0d: busy=%0d done=%0d seq_err=%0d got %h want busy=%0d %h",
                 it, k, ab, r_busy, r_done, r_seq_err, got, exp_busy, want);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [24:0] got, want;
    int cnt, first;
    for (int it = 0; it < 3; it++) begin
      set_table(1, (it == 1) ? 0 : 4, 0);
      run_sweep(1, -1, 1'b0);
      model(1, NV, cnt, first);
      got  = {pass_o[1], abrt_o[1], cnt_o[1], cexv_o[1], cex_o[1], vec[1]};
      want = {cnt == 0, 1'b0, 8'(cnt), cnt > 0, 7'(first < 0 ? 0 : first), 7'h7F};
      total++;
      if (r_timeout || r_busy != 129 || r_seq_err != 0 || r_done != 1 || got !== want) begin
        bad++;
        $display("FAIL back_to_back[%0d]: busy=%0d seq_err=%0d done=%0d got %h want busy=129 %h",
                 it, r_busy, r_seq_err, r_done, got, want);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      start_s[k] = 1'b0;
      abort_s[k] = 1'b0;
      tbl[k]     = '0;
    end
    test_reset;
    test_correct;
    test_stuck0;
    test_inverted;
    test_abort;
    test_reset_mid;
    test_single_bit;
    test_random;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/skolem_sweep_ctrl.md
# skolem_sweep_ctrl

Sweep controller for exhaustive verification of a combinational Skolem-function netlist. It drives every input assignment of the function under test (FUT) in turn. For each vector it samples the FUT output after a programmable settle time and compares it with the specification value: the even-parity relation of the xor-implies family, expected = XOR of all inputs. It counts mismatches and records the first counterexample. It sits beside a synthesized Skolem netlist in the benchmark harness and gives a single pass/fail verdict per run.

## Interface
- N_IN, default 7: number of FUT inputs; the sweep covers 2^N_IN vectors.
- SETTLE, default 1: extra hold cycles per vector before sampling, range 0..15.
- INV_SPEC, default 0: when 1, the expected value is inverted (odd-parity variant).

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  starts a sweep; accepted only in IDLE.
- abort  in  1  ends an active sweep early.
- vec_out  out  N_IN  vector driven to the FUT inputs (bit 0 to FUT input i0).
- fut_out  in  1  FUT output (e.g. i7).
- busy  out  1  high while a sweep is active.
- done  out  1  one-cycle pulse when a sweep completes or aborts.
- pass  out  1  high when the last sweep completed with zero mismatches.
- aborted  out  1  high when the last sweep ended by abort.
- mismatch_cnt  out  N_IN+1  mismatches in the current or last sweep.
- cex_valid  out  1  high once a counterexample has been captured.
- first_cex  out  N_IN  vector of the first mismatch.

## Operation
- FSM states: IDLE, HOLD, SAMPLE, FIN.
- **IDLE**
  - With start=1: clear mismatch_cnt, cex_valid, first_cex, pass and aborted.
  - Set vec_out=0 and the hold counter to SETTLE.
  - Go to HOLD if SETTLE>0, else to SAMPLE.
- **HOLD**
  - Decrement the hold counter.
  - Go to SAMPLE when the counter reaches 1 (or immediately if SETTLE=1).
- **SAMPLE**
  - Compare fut_out with expected = (^vec_out) ^ INV_SPEC.
  - On a mismatch: increment mismatch_cnt. If cex_valid=0, also latch first_cex=vec_out and set cex_valid.
  - If vec_out is all-ones: go to FIN.
  - Otherwise: increment vec_out, reload the hold counter, and go to HOLD (or stay in SAMPLE if SETTLE=0).
- **FIN**: assert done for one cycle, set pass=(mismatch_cnt==0 and aborted==0), then return to IDLE.
- **abort**
  - When abort=1 in HOLD or SAMPLE: go to FIN and set aborted=1.
  - The comparison in that SAMPLE cycle is discarded.
  - pass is forced to 0.
  - abort is ignored in IDLE and FIN.
- start while busy is ignored. start and abort in the same IDLE cycle: start wins and abort is ignored.
- mismatch_cnt is N_IN+1 bits wide, so it holds 2^N_IN without saturation logic.
- vec_out keeps its last value in IDLE after a sweep. Its reset value is 0.

## Timing
- **Reset** (any state, mid-sweep included), next edge:
  - state=IDLE.
  - vec_out, busy, done, pass, aborted, mismatch_cnt, cex_valid, first_cex all 0.
  - No done pulse is produced.
- **busy**: rises on the edge that accepts start, and falls on the edge that leaves FIN. It is high through FIN.
- **Vector timing**
  - Each vector is driven for exactly SETTLE+1 cycles.
  - fut_out is sampled at the rising edge that ends the vector's last cycle.
  - The FUT is combinational, so with SETTLE=0 it has one full cycle to settle.
- **Run length**: a full sweep is busy for 2^N_IN·(SETTLE+1)+1 cycles, the +1 being FIN. done is asserted in the FIN cycle.
- **Output validity**: mismatch_cnt and first_cex update on the edge after the SAMPLE cycle. pass and aborted are valid from the cycle after FIN and hold until the next accepted start or reset.
- **Back-to-back runs**: a new start is accepted in the first IDLE cycle after FIN.

## Test plan
- **Correct FUT** (ideal XNOR-chain netlist), N_IN=7, SETTLE=1: start, then expect busy for 257 cycles, done pulse once, pass=1, mismatch_cnt=0, cex_valid=0, vec_out=7'h7F afterwards.
- **Stuck-at-0 FUT**: fut_out tied 0, then expect mismatch_cnt=64, first_cex=7'h01, pass=0.
- **Inverted FUT**, SETTLE=0: fut_out = ~parity, then expect mismatch_cnt=128, first_cex=7'h00, sweep busy for 129 cycles.
- **Abort**: pulse abort in the SAMPLE cycle of vector 7'h10 with a stuck-at-0 FUT, then expect FIN next, aborted=1, pass=0, mismatch_cnt=8 (vector 16 not counted).
- **Reset mid-sweep and ignored start**
  - Assert rst at vector 7'h40: next cycle all outputs 0, no done pulse.
  - Then start again: the run completes normally.
  - A start pulse while busy leaves vec_out sequence and counts unchanged.
- **Single-bit error FUT**: wrong only at 7'h5A, then expect mismatch_cnt=1, first_cex=7'h5A, cex_valid=1.
